// File: rtl/edge_detect_bank.sv
// -----------------------------------------------------------------------------
// edge_detect_bank
//
// Multi-channel edge detector for asynchronous level inputs (buttons,
// switches, external strobes). Each channel runs:
//   raw level -> SYNC_STAGES-flop synchroniser -> debounce FSM -> edge events
// Edge events come out either same-cycle (Mealy, REG_TICK=0) or one cycle
// later (Moore, REG_TICK=1). Sticky pending flags are provided for polling.
//
// Parameters:
//   WIDTH        number of independent channels (1..32)
//   SYNC_STAGES  synchroniser depth (>=2)
//   DB_CNT       consecutive disagreeing cycles needed to flip filtered
//                (1..255, 1 = no debounce)
//   REG_TICK     0 = Mealy tick, 1 = Moore (registered) tick
//
// Ports:
//   clk          clock, all state on rising edge
//   reset        asynchronous active-high reset, clears all state
//   en           global enable for tick/pending generation
//   level        raw asynchronous inputs
//   rise_en      per-channel rising-edge enable
//   fall_en      per-channel falling-edge enable
//   clr          per-channel synchronous clear of pending
//   filtered     debounced level (registered)
//   rise, fall   one-cycle edge pulses
//   tick         rise | fall
//   pending      sticky event flags (set wins over clr)
//   any_pending  OR-reduction of pending
// -----------------------------------------------------------------------------
module edge_detect_bank #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CNT      = 4,
    parameter int REG_TICK    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] level,
    input  logic [WIDTH-1:0] rise_en,
    input  logic [WIDTH-1:0] fall_en,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] filtered,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] tick,
    output logic [WIDTH-1:0] pending,
    output logic             any_pending
);

    localparam int CNT_W = $clog2(DB_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_t;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            // ------------------------------------------------------------
            // Synchroniser: the only logic that ever sees the raw level.
            // ------------------------------------------------------------
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   s;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], level[gi]};
                end
            end

            assign s = sync_reg[SYNC_STAGES-1];

            // ------------------------------------------------------------
            // Debounce FSM
            // ------------------------------------------------------------
            db_state_t        state_reg, state_next;
            logic [CNT_W-1:0] cnt_reg,   cnt_next;
            logic             filt_reg,  filt_next;
            logic             flip;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg <= ST_STABLE;
                    cnt_reg   <= '0;
                    filt_reg  <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    filt_reg  <= filt_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                filt_next  = filt_reg;
                flip       = 1'b0;
                case (state_reg)
                    ST_STABLE: begin
                        if (s != filt_reg) begin
                            if (DB_CNT == 1) begin
                                // No debounce: the first disagreeing cycle
                                // is already the flip cycle.
                                flip      = 1'b1;
                                filt_next = ~filt_reg;
                                cnt_next  = '0;
                            end else begin
                                state_next = ST_COUNTING;
                                cnt_next   = CNT_W'(1);
                            end
                        end else begin
                            cnt_next = '0;
                        end
                    end
                    ST_COUNTING: begin
                        if (s == filt_reg) begin
                            // Glitch shorter than DB_CNT: drop it silently.
                            state_next = ST_STABLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            flip       = 1'b1;
                            filt_next  = ~filt_reg;
                            cnt_next   = '0;
                            state_next = ST_STABLE;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_next = ST_STABLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            // ------------------------------------------------------------
            // Event generation. Enables are sampled in the flip cycle in
            // both modes, so re-enabling later never replays an old edge.
            // ------------------------------------------------------------
            logic rise_c;
            logic fall_c;
            logic pend_reg;

            assign rise_c = flip & ~filt_reg & rise_en[gi] & en;
            assign fall_c = flip &  filt_reg & fall_en[gi] & en;

            if (REG_TICK != 0) begin : g_moore
                logic rise_reg;
                logic fall_reg;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        rise_reg <= 1'b0;
                        fall_reg <= 1'b0;
                    end else begin
                        rise_reg <= rise_c;
                        fall_reg <= fall_c;
                    end
                end

                assign rise[gi] = rise_reg;
                assign fall[gi] = fall_reg;
            end else begin : g_mealy
                // Registers are cleared asynchronously, so flip (and with it
                // these pulses) is already 0 while reset is held.
                assign rise[gi] = rise_c;
                assign fall[gi] = fall_c;
            end

            // Pending is set from the unregistered event in both modes: in
            // Moore mode that is the same edge that loads the tick register.
            // Set takes priority over clr; en does not clear it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pend_reg <= 1'b0;
                end else begin
                    pend_reg <= (pend_reg & ~clr[gi]) | rise_c | fall_c;
                end
            end

            assign filtered[gi] = filt_reg;
            assign pending[gi]  = pend_reg;
        end
    endgenerate

    assign tick        = rise | fall;
    assign any_pending = |pending;

endmodule

// File: tb/tb_edge_detect_bank.sv
// -----------------------------------------------------------------------------
// tb_edge_detect_bank
//
// Drives a Mealy (REG_TICK=0) and a Moore (REG_TICK=1) instance of
// edge_detect_bank (WIDTH=4, SYNC_STAGES=2, DB_CNT=3) from the same inputs.
// A table of per-cycle vectors with hand-computed expectations covers a
// rising edge, a glitch, a masked rising edge, edges while en=0, clr/set
// collisions and simultaneous multi-channel events. A hand-written sequence
// then checks an asynchronous reset in the middle of a debounce count.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_edge_detect_bank;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] level;
    logic [3:0] rise_en;
    logic [3:0] fall_en;
    logic [3:0] clr;

    logic [3:0] m_filtered, m_rise, m_fall, m_tick, m_pending;
    logic       m_any;
    logic [3:0] o_filtered, o_rise, o_fall, o_tick, o_pending;
    logic       o_any;

    int n_cmp;
    int n_err;

    edge_detect_bank #(
        .WIDTH(4), .SYNC_STAGES(2), .DB_CNT(3), .REG_TICK(0)
    ) dut_mealy (
        .clk(clk), .reset(reset), .en(en), .level(level),
        .rise_en(rise_en), .fall_en(fall_en), .clr(clr),
        .filtered(m_filtered), .rise(m_rise), .fall(m_fall),
        .tick(m_tick), .pending(m_pending), .any_pending(m_any)
    );

    edge_detect_bank #(
        .WIDTH(4), .SYNC_STAGES(2), .DB_CNT(3), .REG_TICK(1)
    ) dut_moore (
        .clk(clk), .reset(reset), .en(en), .level(level),
        .rise_en(rise_en), .fall_en(fall_en), .clr(clr),
        .filtered(o_filtered), .rise(o_rise), .fall(o_fall),
        .tick(o_tick), .pending(o_pending), .any_pending(o_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] level;
        logic       en;
        logic [3:0] clr;
        logic [3:0] e_filt;
        logic [3:0] e_mrise;
        logic [3:0] e_mfall;
        logic [3:0] e_orise;
        logic [3:0] e_ofall;
        logic [3:0] e_pend;
    } vec_t;

    localparam int NVEC = 28;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " m_filtered"}, m_filtered, 4'h0);
        check({tag, " m_rise"},     m_rise,     4'h0);
        check({tag, " m_fall"},     m_fall,     4'h0);
        check({tag, " m_tick"},     m_tick,     4'h0);
        check({tag, " m_pending"},  m_pending,  4'h0);
        check({tag, " m_any"},      {3'b0, m_any}, 4'h0);
        check({tag, " o_filtered"}, o_filtered, 4'h0);
        check({tag, " o_rise"},     o_rise,     4'h0);
        check({tag, " o_fall"},     o_fall,     4'h0);
        check({tag, " o_tick"},     o_tick,     4'h0);
        check({tag, " o_pending"},  o_pending,  4'h0);
        check({tag, " o_any"},      {3'b0, o_any}, 4'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // level, en, clr, filtered, m_rise, m_fall, o_rise, o_fall, pending
        vecs[0]  = '{4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{4'h1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[2]  = '{4'h3, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[3]  = '{4'h7, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[4]  = '{4'hD, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[5]  = '{4'hD, 1'b1, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[6]  = '{4'hD, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1};
        vecs[7]  = '{4'hD, 1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
        vecs[8]  = '{4'hD, 1'b0, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
        vecs[9]  = '{4'hD, 1'b0, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
        vecs[10] = '{4'h9, 1'b1, 4'h1, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
        vecs[11] = '{4'h9, 1'b1, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[12] = '{4'h1, 1'b1, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[13] = '{4'h1, 1'b1, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[14] = '{4'h1, 1'b1, 4'h0, 4'hD, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0};
        vecs[15] = '{4'h1, 1'b1, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4};
        vecs[16] = '{4'h1, 1'b1, 4'h0, 4'h9, 4'h0, 4'h8, 4'h0, 4'h0, 4'h4};
        vecs[17] = '{4'h1, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h8, 4'hC};
        vecs[18] = '{4'h1, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hC};
        vecs[19] = '{4'h1, 1'b1, 4'hC, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hC};
        vecs[20] = '{4'h2, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[21] = '{4'h2, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[22] = '{4'h2, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[23] = '{4'h2, 1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[24] = '{4'h2, 1'b1, 4'h0, 4'h1, 4'h2, 4'h1, 4'h0, 4'h0, 4'h0};
        vecs[25] = '{4'h2, 1'b1, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 4'h1, 4'h3};
        vecs[26] = '{4'h2, 1'b1, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3};
        vecs[27] = '{4'h2, 1'b1, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h3};

        // Reset state
        reset   = 1'b1;
        en      = 1'b1;
        level   = 4'h0;
        rise_en = 4'b1011;   // ch2 rising edges masked
        fall_en = 4'hF;
        clr     = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        $display("reset held: outputs checked");

        @(posedge clk);
        #1;
        reset = 1'b0;

        // Table-driven vectors
        for (int k = 0; k < NVEC; k++) begin
            level = vecs[k].level;
            en    = vecs[k].en;
            clr   = vecs[k].clr;
            @(negedge clk);
            check($sformatf("v%0d m_filtered", k), m_filtered, vecs[k].e_filt);
            check($sformatf("v%0d o_filtered", k), o_filtered, vecs[k].e_filt);
            check($sformatf("v%0d m_rise", k), m_rise, vecs[k].e_mrise);
            check($sformatf("v%0d m_fall", k), m_fall, vecs[k].e_mfall);
            check($sformatf("v%0d m_tick", k), m_tick, vecs[k].e_mrise | vecs[k].e_mfall);
            check($sformatf("v%0d o_rise", k), o_rise, vecs[k].e_orise);
            check($sformatf("v%0d o_fall", k), o_fall, vecs[k].e_ofall);
            check($sformatf("v%0d o_tick", k), o_tick, vecs[k].e_orise | vecs[k].e_ofall);
            check($sformatf("v%0d m_pending", k), m_pending, vecs[k].e_pend);
            check($sformatf("v%0d o_pending", k), o_pending, vecs[k].e_pend);
            check($sformatf("v%0d m_any", k), {3'b0, m_any}, {3'b0, |vecs[k].e_pend});
            check($sformatf("v%0d o_any", k), {3'b0, o_any}, {3'b0, |vecs[k].e_pend});
            $display("vec %0d: level=%h en=%b clr=%h filt=%h mrise=%h mfall=%h orise=%h ofall=%h pend=%h",
                     k, level, en, clr, m_filtered, m_rise, m_fall, o_rise, o_fall, m_pending);
            @(posedge clk);
            #1;
        end

        // Reset in the middle of a debounce count (ch0 rising, cnt=2)
        clr   = 4'h0;
        en    = 1'b1;
        level = 4'h3;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("midcount m_rise", m_rise, 4'h1);
        check("midcount o_rise", o_rise, 4'h0);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("async reset");
        $display("reset asserted mid-count: outputs checked");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Both high channels report a boot rising edge after full latency.
        for (int j = 0; j < 7; j++) begin
            @(negedge clk);
            check($sformatf("post-reset c%0d m_rise", j), m_rise, (j == 4) ? 4'h3 : 4'h0);
            check($sformatf("post-reset c%0d o_rise", j), o_rise, (j == 5) ? 4'h3 : 4'h0);
            check($sformatf("post-reset c%0d m_fall", j), m_fall, 4'h0);
            check($sformatf("post-reset c%0d o_fall", j), o_fall, 4'h0);
            check($sformatf("post-reset c%0d filtered", j), m_filtered, (j >= 5) ? 4'h3 : 4'h0);
            check($sformatf("post-reset c%0d o_pending", j), o_pending, (j >= 5) ? 4'h3 : 4'h0);
            $display("post-reset %0d: mrise=%h orise=%h filt=%h pend=%h",
                     j, m_rise, o_rise, m_filtered, o_pending);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edge_detect_bank.md
Name: edge_detect_bank

Overview:
- Multi-channel, parametrised edge detector for asynchronous level inputs such as buttons, switches and external strobes.
- Each channel has a synchroniser, a debounce filter, and independently enabled rising/falling edge detection.
- Output is either Mealy-style (same-cycle) or Moore-style (registered) tick pulses, plus sticky pending flags for software/FSM polling.
- Sits between the board I/O pins and the control FSMs.

Parameters:
- WIDTH, 4, number of independent channels (1..32).
- SYNC_STAGES, 2, flip-flops in each input synchroniser chain (>=2).
- DB_CNT, 4, consecutive cycles the synchronised level must differ from the filtered level before the filtered level flips (1..255; 1 = no debounce).
- REG_TICK, 0, 0 = Mealy tick (combinational, same cycle as the flip decision); 1 = Moore tick (registered, one cycle later).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- en  in  1  global enable for tick/pending generation.
- level  in  WIDTH  raw asynchronous inputs.
- rise_en  in  WIDTH  per-channel enable for rising-edge events.
- fall_en  in  WIDTH  per-channel enable for falling-edge events.
- clr  in  WIDTH  per-channel synchronous clear of pending.
- filtered  out  WIDTH  debounced level, registered.
- rise  out  WIDTH  one-cycle rising-edge pulse (qualified by rise_en and en).
- fall  out  WIDTH  one-cycle falling-edge pulse (qualified by fall_en and en).
- tick  out  WIDTH  rise | fall.
- pending  out  WIDTH  sticky event flags.
- any_pending  out  1  OR-reduction of pending.

Behaviour:
- Reset, asynchronous:
  - Synchroniser flops, debounce counters, filtered, pending and the Moore tick registers all go to 0.
  - Mealy outputs are 0 while reset is high.
  - A channel whose level is high at reset release reports one rising edge after the normal latency. This is intentional boot-edge behaviour.
- Synchroniser: level[i] passes through SYNC_STAGES flops to give s[i]. No other logic touches raw level.
- Per-channel debounce FSM, with states STABLE and COUNTING; counter width is ceil(log2(DB_CNT+1)):
  - STABLE: if s == filtered, stay with cnt = 0. If s != filtered, go to COUNTING with cnt = 1, or flip immediately if DB_CNT == 1.
  - COUNTING: if s == filtered (glitch), return to STABLE, cnt = 0, no event. If s != filtered and cnt == DB_CNT-1, this is the flip cycle.
  - Flip cycle: filtered <= ~filtered, cnt <= 0, return to STABLE. Otherwise cnt increments.
- Event generation:
  - raw_rise = flip & ~filtered; raw_fall = flip & filtered. Both are evaluated in the flip cycle.
  - rise = raw_rise & rise_en & en; fall = raw_fall & fall_en & en.
  - REG_TICK=0: rise, fall and tick are high during the flip cycle; filtered changes at the end of it.
  - REG_TICK=1: rise, fall and tick are registered versions, high the cycle after the flip cycle, coincident with the new filtered value.
  - rise_en, fall_en and en are sampled in the flip cycle in both modes.
  - Each pulse is exactly one cycle wide per filtered transition. A held level never re-ticks.
- Filtering continues while en=0 or while a channel's edge enables are 0. Re-enabling never produces a stale or spurious event.
- Pending:
  - pending[i] sets on the clock edge after tick[i] is high in Mealy mode, and on the same edge tick registers in Moore mode.
  - clr[i] clears pending[i].
  - If set and clr occur in the same cycle, set wins.
  - pending is never cleared by en=0.
- Latency example (SYNC_STAGES=2, DB_CNT=3, level stable high before edge E0):
  - s = 1 after E1; cnt 1 after E2, 2 after E3.
  - Mealy rise is high between E3 and E4; filtered = 1 after E4.
  - Moore rise is high between E4 and E5.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse in the same cycle.
- Reset asserted mid-count discards the count and any in-flight Moore tick. No event appears after release unless the input criteria are met again.

Test Plan:
- REG_TICK=0, SYNC=2, DB=3, ch0 level 0->1 held, rise_en=1, en=1 -> rise[0] high exactly 1 cycle (E3–E4), filtered[0]=1 after E4, pending[0]=1 after E4.
- Same config, ch1 glitch high for 2 cycles at s -> no rise/fall/tick, filtered[1] stays 0, cnt returns to 0.
- REG_TICK=1, ch2 falling edge, fall_en=1, rise_en=0 -> fall[2] one cycle between E4 and E5; matching rising edge produces no tick but filtered[2] still follows.
- en=0 during a rising edge on ch3, then en=1 -> no tick, no pending, filtered[3]=1; later fall with en=1 gives exactly one fall pulse.
- clr[0] asserted in the same cycle pending[0] sets, then clr alone -> pending stays 1, then goes 0; any_pending tracks the OR of all channels.
- Reset pulse while ch0 cnt=2, level held high -> outputs 0 immediately; after release, rise[0] after the full SYNC+DB latency measured from release.
